// File: rtl/tag_ram_ctrl_pkg.sv
// Tag RAM controller shared definitions.
// State encodings, valid-bit position and default widths.
package tag_ram_ctrl_pkg;

  localparam int DEF_AWIDTH = 3;
  localparam int DEF_DWIDTH = 14;
  localparam int VALID_BIT  = DEF_DWIDTH - 1;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

endpackage

// File: rtl/tag_ram_ctrl_match.sv
// Tag RAM controller: valid + tag comparator.
// Pure combinational; the word's top bit is the valid flag.
module tag_match
  import tag_ram_ctrl_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic [DWIDTH-1:0] word,
  input  logic [DWIDTH-2:0] tag,
  output logic              hit
);

  // A hit needs a valid entry whose stored tag equals the request tag
  assign hit = word[DWIDTH-1] && (word[DWIDTH-2:0] == tag);

endmodule

// File: rtl/tag_ram_ctrl.sv
// Tag RAM controller: lookup/fill FSM in front of a sync-read tag RAM.
// Define TAG_RAM_CTRL_INIT_EN to clear the RAM after every reset.
module tag_ram_ctrl
  import tag_ram_ctrl_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fill,
  input  logic [AWIDTH-1:0] req_index,
  input  logic [DWIDTH-2:0] req_tag,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AWIDTH-1:0] rsp_index,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  logic [2:0]        state;
  logic [DWIDTH-2:0] cap_tag;
  logic              hit;
`ifdef TAG_RAM_CTRL_INIT_EN
  logic [AWIDTH-1:0] cnt;
`endif

  assign req_ready = (state == S_IDLE);

  tag_match #(
    .DWIDTH(DWIDTH)
  ) u_match (
    .word(ram_dout),
    .tag (cap_tag),
    .hit (hit)
  );

  // FSM plus all registered RAM-side and response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef TAG_RAM_CTRL_INIT_EN
      state     <= S_INIT;
      cnt       <= '0;
`else
      state     <= S_IDLE;
`endif
      cap_tag   <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_index <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      ram_we    <= 1'b0;
      unique case (state)
`ifdef TAG_RAM_CTRL_INIT_EN
        S_INIT: begin
          ram_din <= '0;
          // leave once the last index has been written
          if (ram_we && (&ram_addr)) begin
            state <= S_IDLE;
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= cnt;
            cnt      <= cnt + 1'b1;
          end
        end
`endif
        S_IDLE: begin
          if (req_valid) begin
            ram_addr <= req_index;
            cap_tag  <= req_tag;
            if (req_fill) begin
              ram_we  <= 1'b1;
              ram_din <= {1'b1, req_tag};
              state   <= S_WRITE;
            end else begin
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_CMP;
        end
        S_CMP: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= hit;
          rsp_index <= ram_addr;
          state     <= S_IDLE;
        end
        S_WRITE: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_index <= ram_addr;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Bench for tag_ram_ctrl with a sync-read single-port RAM model.
// Responses are scored against a queue filled at request accept.
module tb_tag_ram_ctrl;

  localparam int AW = 3;
  localparam int DW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_fill = 1'b0;
  logic [AW-1:0] req_index = '0;
  logic [DW-2:0] req_tag = '0;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [AW-1:0] rsp_index;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [8] = '{default: '0};
  logic [DW-1:0] ref_mem [8] = '{default: '0};

  typedef struct {
    logic          hit;
    logic [AW-1:0] idx;
    int            due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   accepts = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  tag_ram_ctrl #(
    .AWIDTH(AW),
    .DWIDTH(DW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_fill (req_fill),
    .req_index(req_index),
    .req_tag  (req_tag),
    .rsp_valid(rsp_valid),
    .rsp_hit  (rsp_hit),
    .rsp_index(rsp_index),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  // One clock: score at negedge, then land 1 time unit after posedge.
  task automatic step();
    exp_t e;
    @(negedge clock);
    if (reset) begin
      q.delete();
`ifdef TAG_RAM_CTRL_INIT_EN
      for (int i = 0; i < 8; i++) ref_mem[i] = '0;
`endif
    end else begin
      if (rsp_valid) begin
        pulses++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL extra_rsp cyc=%0d idx=%0d hit=%0b want no pulse",
                   cyc, rsp_index, rsp_hit);
        end else begin
          e = q.pop_front();
          if (rsp_hit !== e.hit || rsp_index !== e.idx || cyc !== e.due) begin
            failures++;
            $display("FAIL rsp got hit=%0b idx=%0d cyc=%0d want hit=%0b idx=%0d cyc=%0d",
                     rsp_hit, rsp_index, cyc, e.hit, e.idx, e.due);
          end
        end
      end
      if (req_valid && req_ready) begin
        accepts++;
        e.idx = req_index;
        if (req_fill) begin
          e.hit = 1'b0;
          e.due = cyc + 2;
          ref_mem[req_index] = {1'b1, req_tag};
        end else begin
          e.hit = ref_mem[req_index][DW-1] &&
                  (ref_mem[req_index][DW-2:0] == req_tag);
          e.due = cyc + 3;
        end
        q.push_back(e);
      end
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0 || !req_ready) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d ready=%0b want 0 and 1",
               q.size(), req_ready);
    end
  endtask

  task automatic do_req(input logic fill, input logic [AW-1:0] idx,
                        input logic [DW-2:0] tag);
    req_valid = 1'b1;
    req_fill  = fill;
    req_index = idx;
    req_tag   = tag;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready got=%0b want=1", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_rsp_valid got=%0b want=0", rsp_valid);
    end
    checks++;
    if (rsp_hit !== 1'b0 || rsp_index !== '0) begin
      failures++;
      $display("FAIL rst_rsp got hit=%0b idx=%0d want 0 0", rsp_hit, rsp_index);
    end
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0) begin
      failures++;
      $display("FAIL rst_ram got we=%0b addr=%0d din=%h want 0 0 0",
               ram_we, ram_addr, ram_din);
    end
`ifdef TAG_RAM_CTRL_INIT_EN
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL init_ready got=%0b want=0", req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_din !== '0 ||
          req_ready !== 1'b0) begin
        failures++;
        $display("FAIL init_sweep got we=%0b addr=%0d din=%h rdy=%0b want 1 %0d 0 0",
                 ram_we, ram_addr, ram_din, req_ready, i);
      end
    end
    step();
    checks++;
    if (ram_we !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_end got we=%0b rdy=%0b want 0 1", ram_we, req_ready);
    end
`else
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%0b want=1", req_ready);
    end
`endif
  endtask

  task automatic test_fill_lookup();
    do_req(1'b1, 3'd5, 13'h0ABC);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 3'd5 || ram_din !== 14'h2ABC) begin
      failures++;
      $display("FAIL fill_ram got we=%0b addr=%0d din=%h want 1 5 2abc",
               ram_we, ram_addr, ram_din);
    end
    step();
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL fill_we_drop got=%0b want=0", ram_we);
    end
    drain(10);
    do_req(1'b0, 3'd5, 13'h0ABC);
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 3'd5) begin
      failures++;
      $display("FAIL lookup_ram got we=%0b addr=%0d want 0 5", ram_we, ram_addr);
    end
    drain(10);
  endtask

  task automatic test_miss();
    do_req(1'b0, 3'd5, 13'h0ABD);
    drain(10);
    do_req(1'b0, 3'd2, 13'h0000);
    drain(10);
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 3'd3, 13'h1234);
    step();
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_window got rsp=%0b rdy=%0b want 1 1", rsp_valid, req_ready);
    end
    do_req(1'b0, 3'd3, 13'h1234);
    drain(10);
  endtask

  task automatic test_backpressure();
    int a0 = accepts;
    int p0 = pulses;
    req_valid = 1'b1;
    req_fill  = 1'b0;
    req_index = 3'd5;
    req_tag   = 13'h0ABC;
    repeat (10) step();
    req_valid = 1'b0;
    checks++;
    if (accepts - a0 !== 4) begin
      failures++;
      $display("FAIL bp_accepts got=%0d want=4", accepts - a0);
    end
    checks++;
    if (pulses - p0 !== 3) begin
      failures++;
      $display("FAIL bp_pulses got=%0d want=3", pulses - p0);
    end
    drain(10);
    repeat (4) step();
  endtask

  task automatic test_reset_midop();
    do_req(1'b0, 3'd1, 13'h0011);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL midop_rst got rsp=%0b we=%0b want 0 0", rsp_valid, ram_we);
    end
    checks++;
`ifdef TAG_RAM_CTRL_INIT_EN
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL midop_state got rdy=%0b want 0 (INIT)", req_ready);
    end
`else
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_state got rdy=%0b want 1 (IDLE)", req_ready);
    end
`endif
    drain(20);
    repeat (4) step();
  endtask

`ifdef TAG_RAM_CTRL_INIT_EN
  task automatic test_wrap();
    do_req(1'b1, 3'd7, 13'h0077);
    drain(10);
    do_req(1'b0, 3'd7, 13'h0077);
    drain(10);
    test_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== '0) begin
        failures++;
        $display("FAIL wrap_mem[%0d] got=%h want=0", i, mem[i]);
      end
    end
    do_req(1'b0, 3'd7, 13'h0077);
    drain(10);
    do_req(1'b0, 3'd7, 13'h0000);
    drain(10);
  endtask
`endif

  initial begin
    test_reset();
    test_fill_lookup();
    test_miss();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
`ifdef TAG_RAM_CTRL_INIT_EN
    test_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
